// File: rtl/mouse_click_decoder_if.sv
// Mouse event inputs and decoded hover/click/drag outputs of the click decoder.
// The master side drives mouse samples. The slave side (the decoder) drives the results.
interface mouse_click_decoder_if;
    logic [9:0] mouse_x;
    logic [9:0] mouse_y;
    logic       mouse_left;
    logic       mouse_right;
    logic       mouse_new_event;

    logic       hover_valid;
    logic [4:0] hover_col;
    logic [4:0] hover_row;
    logic       click_pulse;
    logic       click_button;
    logic       click_dbl;
    logic [4:0] click_col;
    logic [4:0] click_row;
    logic       drag_active;
    logic [4:0] drag_col;
    logic [4:0] drag_row;

    modport master (
        output mouse_x, mouse_y, mouse_left, mouse_right, mouse_new_event,
        input  hover_valid, hover_col, hover_row,
        input  click_pulse, click_button, click_dbl, click_col, click_row,
        input  drag_active, drag_col, drag_row
    );

    modport slave (
        input  mouse_x, mouse_y, mouse_left, mouse_right, mouse_new_event,
        output hover_valid, hover_col, hover_row,
        output click_pulse, click_button, click_dbl, click_col, click_row,
        output drag_active, drag_col, drag_row
    );
endinterface

// File: rtl/mouse_click_decoder.sv
// Maps strobed mouse samples onto a cell grid: hover, left/right click, double-click and drag.
// Latency: 2 cycles from strobe to outputs. No backpressure: every strobed event is consumed.
module mouse_click_decoder #(
    parameter int GRID_X0    = 0,
    parameter int GRID_Y0    = 0,
    parameter int CELL_SHIFT = 5,
    parameter int GRID_COLS  = 20,
    parameter int GRID_ROWS  = 15,
    parameter int DBL_CYCLES = 32400000
) (
    input  logic                 clk,
    input  logic                 rst,
    mouse_click_decoder_if.slave mcd
);
    typedef enum logic [1:0] {IDLE, L_PRESS, L_DRAG, R_PRESS} state_t;

    localparam logic [10:0] X_LO     = 11'(GRID_X0);
    localparam logic [10:0] X_HI     = 11'(GRID_X0 + (GRID_COLS << CELL_SHIFT));
    localparam logic [10:0] Y_LO     = 11'(GRID_Y0);
    localparam logic [10:0] Y_HI     = 11'(GRID_Y0 + (GRID_ROWS << CELL_SHIFT));
    localparam logic [24:0] DBL_LOAD = 25'(DBL_CYCLES);

    state_t      r_state;
    state_t      w_state_nxt;

    logic [9:0]  r_s_x;
    logic [9:0]  r_s_y;
    logic        r_s_l;
    logic        r_s_r;
    logic        r_s_vld;
    logic        r_prev_l;
    logic        r_prev_r;
    logic [4:0]  r_anchor_col;
    logic [4:0]  r_anchor_row;
    logic [4:0]  r_last_col;
    logic [4:0]  r_last_row;
    logic [24:0] r_dbl_cnt;

    logic        r_hover_valid;
    logic [4:0]  r_hover_col;
    logic [4:0]  r_hover_row;
    logic        r_click_pulse;
    logic        r_click_button;
    logic        r_click_dbl;
    logic [4:0]  r_click_col;
    logic [4:0]  r_click_row;
    logic        r_drag_active;
    logic [4:0]  r_drag_col;
    logic [4:0]  r_drag_row;

    logic [10:0] w_x11;
    logic [10:0] w_y11;
    logic [10:0] w_dx;
    logic [10:0] w_dy;
    logic        w_inside;
    logic [4:0]  w_col;
    logic [4:0]  w_row;
    logic        w_rise_l;
    logic        w_rise_r;
    logic        w_at_anchor;
    logic        w_same_last;
    logic        w_click;
    logic        w_click_btn;
    logic        w_capture;

    // Sample stage: only strobed cycles update the sample registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s_x   <= '0;
            r_s_y   <= '0;
            r_s_l   <= 1'b0;
            r_s_r   <= 1'b0;
            r_s_vld <= 1'b0;
        end else begin
            r_s_vld <= mcd.mouse_new_event;
            if (mcd.mouse_new_event) begin
                r_s_x <= mcd.mouse_x;
                r_s_y <= mcd.mouse_y;
                r_s_l <= mcd.mouse_left;
                r_s_r <= mcd.mouse_right;
            end
        end
    end

    assign w_x11       = {1'b0, r_s_x};
    assign w_y11       = {1'b0, r_s_y};
    assign w_inside    = (w_x11 >= X_LO) && (w_x11 < X_HI) && (w_y11 >= Y_LO) && (w_y11 < Y_HI);
    assign w_dx        = w_x11 - X_LO;
    assign w_dy        = w_y11 - Y_LO;
    assign w_col       = 5'(w_dx >> CELL_SHIFT);
    assign w_row       = 5'(w_dy >> CELL_SHIFT);
    assign w_rise_l    = r_s_l && !r_prev_l;
    assign w_rise_r    = r_s_r && !r_prev_r;
    assign w_at_anchor = (w_col == r_anchor_col) && (w_row == r_anchor_row);
    assign w_same_last = (w_col == r_last_col) && (w_row == r_last_row);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_click     = 1'b0;
        w_click_btn = 1'b0;
        w_capture   = 1'b0;
        if (r_s_vld) begin
            case (r_state)
                IDLE: begin
                    // Left wins when both buttons rise in the same event.
                    if (w_rise_l && w_inside) begin
                        w_state_nxt = L_PRESS;
                        w_capture   = 1'b1;
                    end else if (w_rise_r && !r_s_l && w_inside) begin
                        w_state_nxt = R_PRESS;
                        w_capture   = 1'b1;
                    end
                end
                L_PRESS: begin
                    if (!r_s_l) begin
                        w_state_nxt = IDLE;
                        w_click     = w_inside && w_at_anchor;
                    end else if (!w_inside || !w_at_anchor) begin
                        w_state_nxt = L_DRAG;
                    end
                end
                L_DRAG: begin
                    if (!r_s_l) w_state_nxt = IDLE;
                end
                R_PRESS: begin
                    if (w_rise_l) begin
                        w_state_nxt = IDLE;
                    end else if (!r_s_r) begin
                        w_state_nxt = IDLE;
                        w_click     = w_inside && w_at_anchor;
                        w_click_btn = 1'b1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_l       <= 1'b0;
            r_prev_r       <= 1'b0;
            r_anchor_col   <= '0;
            r_anchor_row   <= '0;
            r_last_col     <= '0;
            r_last_row     <= '0;
            r_dbl_cnt      <= '0;
            r_hover_valid  <= 1'b0;
            r_hover_col    <= '0;
            r_hover_row    <= '0;
            r_click_pulse  <= 1'b0;
            r_click_button <= 1'b0;
            r_click_dbl    <= 1'b0;
            r_click_col    <= '0;
            r_click_row    <= '0;
            r_drag_active  <= 1'b0;
            r_drag_col     <= '0;
            r_drag_row     <= '0;
        end else begin
            if (r_s_vld) begin
                r_prev_l      <= r_s_l;
                r_prev_r      <= r_s_r;
                r_hover_valid <= w_inside;
                if (w_inside) begin
                    r_hover_col <= w_col;
                    r_hover_row <= w_row;
                end
            end
            if (w_capture) begin
                r_anchor_col <= w_col;
                r_anchor_row <= w_row;
            end

            r_click_pulse <= w_click;
            if (w_click) begin
                r_click_button <= w_click_btn;
                r_click_col    <= w_col;
                r_click_row    <= w_row;
            end

            // Double-click window: a qualifying second click consumes the window.
            if (w_click && !w_click_btn) begin
                r_last_col <= w_col;
                r_last_row <= w_row;
                if ((r_dbl_cnt != '0) && w_same_last) begin
                    r_click_dbl <= 1'b1;
                    r_dbl_cnt   <= '0;
                end else begin
                    r_click_dbl <= 1'b0;
                    r_dbl_cnt   <= DBL_LOAD;
                end
            end else if (w_click) begin
                r_click_dbl <= 1'b0;
                r_dbl_cnt   <= '0;
            end else if (r_dbl_cnt != '0) begin
                r_dbl_cnt <= r_dbl_cnt - 25'd1;
            end

            r_drag_active <= (w_state_nxt == L_DRAG);
            if ((w_state_nxt == L_DRAG) && (r_state != L_DRAG)) begin
                r_drag_col <= r_anchor_col;
                r_drag_row <= r_anchor_row;
            end
        end
    end

    assign mcd.hover_valid  = r_hover_valid;
    assign mcd.hover_col    = r_hover_col;
    assign mcd.hover_row    = r_hover_row;
    assign mcd.click_pulse  = r_click_pulse;
    assign mcd.click_button = r_click_button;
    assign mcd.click_dbl    = r_click_dbl;
    assign mcd.click_col    = r_click_col;
    assign mcd.click_row    = r_click_row;
    assign mcd.drag_active  = r_drag_active;
    assign mcd.drag_col     = r_drag_col;
    assign mcd.drag_row     = r_drag_row;
endmodule

// File: tb/tb_mouse_click_decoder.sv
// Directed bench for mouse_click_decoder: vector table plus multi-cycle click/reset/quiet sequences.
`timescale 1ns/1ps
module tb_mouse_click_decoder;
    localparam int DBL = 2000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mouse_click_decoder_if mcd_if();

    mouse_click_decoder #(
        .GRID_X0(0), .GRID_Y0(0), .CELL_SHIFT(5),
        .GRID_COLS(20), .GRID_ROWS(15), .DBL_CYCLES(DBL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mcd(mcd_if)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       l;
        logic       r;
        logic       hv;
        logic [4:0] hc;
        logic [4:0] hr;
        logic       ck;
        logic       btn;
        logic       dbl;
        logic [4:0] cc;
        logic [4:0] cr;
        logic       dg;
        logic [4:0] dc;
        logic [4:0] dr;
    } vec_t;

    vec_t tbl[22];

    function automatic vec_t mk(input int x, y, l, r, hv, hc, hr, ck, btn, dbl, cc, cr, dg, dc, dr);
        vec_t v;
        v.x = 10'(x);  v.y = 10'(y);  v.l = 1'(l);   v.r = 1'(r);
        v.hv = 1'(hv); v.hc = 5'(hc); v.hr = 5'(hr);
        v.ck = 1'(ck); v.btn = 1'(btn); v.dbl = 1'(dbl);
        v.cc = 5'(cc); v.cr = 5'(cr);
        v.dg = 1'(dg); v.dc = 5'(dc); v.dr = 5'(dr);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic send_event(input int x, y, l, r);
        @(negedge clk);
        mcd_if.mouse_x         = 10'(x);
        mcd_if.mouse_y         = 10'(y);
        mcd_if.mouse_left      = 1'(l);
        mcd_if.mouse_right     = 1'(r);
        mcd_if.mouse_new_event = 1'b1;
        @(negedge clk);
        mcd_if.mouse_new_event = 1'b0;
    endtask

    // Call right after the releasing send_event: pulse must appear on the next negedge only, for one cycle.
    task automatic expect_click(input string nm, input int btn, dbl, col, row);
        chk($sformatf("%s early", nm), 32'(mcd_if.click_pulse), 32'd0);
        @(negedge clk);
        chk($sformatf("%s pulse", nm),  32'(mcd_if.click_pulse),  32'd1);
        chk($sformatf("%s button", nm), 32'(mcd_if.click_button), 32'(btn));
        chk($sformatf("%s dbl", nm),    32'(mcd_if.click_dbl),    32'(dbl));
        chk($sformatf("%s col", nm),    32'(mcd_if.click_col),    32'(col));
        chk($sformatf("%s row", nm),    32'(mcd_if.click_row),    32'(row));
        @(negedge clk);
        chk($sformatf("%s width", nm),  32'(mcd_if.click_pulse),  32'd0);
    endtask

    task automatic expect_no_click(input string nm);
        int seen;
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            if (mcd_if.click_pulse) seen++;
            @(negedge clk);
        end
        chk($sformatf("%s no pulse", nm), 32'(seen), 32'd0);
    endtask

    task automatic do_click(input string nm, input int x, y, dbl, col, row);
        send_event(x, y, 1, 0);
        send_event(x + 1, y + 1, 0, 0);
        expect_click(nm, 0, dbl, col, row);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;

        tbl[0]  = mk(100, 40, 1, 0, 1, 3, 1,   0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(101, 41, 0, 0, 1, 3, 1,   1, 0, 0, 3, 1, 0, 0, 0);
        tbl[2]  = mk(100, 40, 1, 0, 1, 3, 1,   0, 0, 0, 3, 1, 0, 0, 0);
        tbl[3]  = mk(200, 40, 1, 0, 1, 6, 1,   0, 0, 0, 3, 1, 1, 3, 1);
        tbl[4]  = mk(300, 100, 1, 0, 1, 9, 3,  0, 0, 0, 3, 1, 1, 3, 1);
        tbl[5]  = mk(300, 100, 0, 0, 1, 9, 3,  0, 0, 0, 3, 1, 0, 3, 1);
        tbl[6]  = mk(700, 40, 0, 0, 0, 9, 3,   0, 0, 0, 3, 1, 0, 3, 1);
        tbl[7]  = mk(700, 40, 1, 0, 0, 9, 3,   0, 0, 0, 3, 1, 0, 3, 1);
        tbl[8]  = mk(700, 40, 0, 0, 0, 9, 3,   0, 0, 0, 3, 1, 0, 3, 1);
        tbl[9]  = mk(639, 479, 0, 0, 1, 19, 14, 0, 0, 0, 3, 1, 0, 3, 1);
        tbl[10] = mk(640, 479, 0, 0, 0, 19, 14, 0, 0, 0, 3, 1, 0, 3, 1);
        tbl[11] = mk(639, 480, 0, 0, 0, 19, 14, 0, 0, 0, 3, 1, 0, 3, 1);
        tbl[12] = mk(50, 50, 0, 1, 1, 1, 1,    0, 0, 0, 3, 1, 0, 3, 1);
        tbl[13] = mk(60, 60, 0, 0, 1, 1, 1,    1, 1, 0, 1, 1, 0, 3, 1);
        tbl[14] = mk(50, 50, 0, 1, 1, 1, 1,    0, 0, 0, 1, 1, 0, 3, 1);
        tbl[15] = mk(100, 50, 0, 0, 1, 3, 1,   0, 0, 0, 1, 1, 0, 3, 1);
        tbl[16] = mk(50, 50, 1, 1, 1, 1, 1,    0, 0, 0, 1, 1, 0, 3, 1);
        tbl[17] = mk(50, 50, 0, 1, 1, 1, 1,    1, 0, 0, 1, 1, 0, 3, 1);
        tbl[18] = mk(50, 50, 0, 0, 1, 1, 1,    0, 0, 0, 1, 1, 0, 3, 1);
        tbl[19] = mk(50, 50, 0, 1, 1, 1, 1,    0, 0, 0, 1, 1, 0, 3, 1);
        tbl[20] = mk(50, 50, 1, 1, 1, 1, 1,    0, 0, 0, 1, 1, 0, 3, 1);
        tbl[21] = mk(50, 50, 0, 0, 1, 1, 1,    0, 0, 0, 1, 1, 0, 3, 1);

        rst = 1'b1;
        mcd_if.mouse_x = '0;
        mcd_if.mouse_y = '0;
        mcd_if.mouse_left = 1'b0;
        mcd_if.mouse_right = 1'b0;
        mcd_if.mouse_new_event = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset hover_valid", 32'(mcd_if.hover_valid), 32'd0);
        chk("reset click_pulse", 32'(mcd_if.click_pulse), 32'd0);
        chk("reset drag_active", 32'(mcd_if.drag_active), 32'd0);
        chk("reset click_col",   32'(mcd_if.click_col),   32'd0);
        chk("reset hover_col",   32'(mcd_if.hover_col),   32'd0);
        rst = 1'b0;

        for (int i = 0; i < 22; i++) begin
            send_event(tbl[i].x, tbl[i].y, tbl[i].l, tbl[i].r);
            @(negedge clk);
            chk($sformatf("v%0d hover_valid", i), 32'(mcd_if.hover_valid), 32'(tbl[i].hv));
            chk($sformatf("v%0d hover_col", i),   32'(mcd_if.hover_col),   32'(tbl[i].hc));
            chk($sformatf("v%0d hover_row", i),   32'(mcd_if.hover_row),   32'(tbl[i].hr));
            chk($sformatf("v%0d click_pulse", i), 32'(mcd_if.click_pulse), 32'(tbl[i].ck));
            chk($sformatf("v%0d click_col", i),   32'(mcd_if.click_col),   32'(tbl[i].cc));
            chk($sformatf("v%0d click_row", i),   32'(mcd_if.click_row),   32'(tbl[i].cr));
            chk($sformatf("v%0d drag_active", i), 32'(mcd_if.drag_active), 32'(tbl[i].dg));
            chk($sformatf("v%0d drag_col", i),    32'(mcd_if.drag_col),    32'(tbl[i].dc));
            chk($sformatf("v%0d drag_row", i),    32'(mcd_if.drag_row),    32'(tbl[i].dr));
            if (tbl[i].ck) begin
                chk($sformatf("v%0d click_button", i), 32'(mcd_if.click_button), 32'(tbl[i].btn));
                chk($sformatf("v%0d click_dbl", i),    32'(mcd_if.click_dbl),    32'(tbl[i].dbl));
            end
        end

        // Double-click window behaviour.
        do_reset();
        do_click("c1 first", 100, 40, 0, 3, 1);
        repeat (1000) @(negedge clk);
        do_click("c2 double", 100, 40, 1, 3, 1);
        do_click("c3 triple", 100, 40, 0, 3, 1);
        repeat (DBL + 51) @(negedge clk);
        do_click("c4 expired", 100, 40, 0, 3, 1);
        do_click("c5 double", 100, 40, 1, 3, 1);
        do_click("c6 single", 100, 40, 0, 3, 1);
        do_click("c7 other cell", 300, 100, 0, 9, 3);
        send_event(300, 100, 0, 1);
        send_event(300, 100, 0, 0);
        expect_click("c8 right", 1, 0, 9, 3);
        do_click("c9 after right", 300, 100, 0, 9, 3);

        // Asynchronous reset during a drag.
        send_event(100, 40, 1, 0);
        send_event(200, 40, 1, 0);
        @(negedge clk);
        chk("drag active", 32'(mcd_if.drag_active), 32'd1);
        chk("drag col",    32'(mcd_if.drag_col),    32'd3);
        chk("drag row",    32'(mcd_if.drag_row),    32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst drag_active", 32'(mcd_if.drag_active), 32'd0);
        chk("async rst hover_valid", 32'(mcd_if.hover_valid), 32'd0);
        chk("async rst drag_col",    32'(mcd_if.drag_col),    32'd0);
        @(negedge clk);
        rst = 1'b0;
        send_event(200, 40, 0, 0);
        expect_no_click("release after rst");

        // Button held through reset counts as a fresh press.
        send_event(100, 40, 1, 0);
        do_reset();
        send_event(100, 40, 1, 0);
        send_event(100, 40, 0, 0);
        expect_click("held through rst", 0, 0, 3, 1);

        // Input activity without a strobe must be invisible.
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            mcd_if.mouse_x     = 10'(i * 7);
            mcd_if.mouse_y     = 10'(i * 5);
            mcd_if.mouse_left  = ~mcd_if.mouse_left;
            mcd_if.mouse_right = ~mcd_if.mouse_right;
            if (mcd_if.click_pulse || mcd_if.drag_active || !mcd_if.hover_valid ||
                mcd_if.hover_col != 5'd3 || mcd_if.hover_row != 5'd1)
                bad++;
        end
        chk("quiet glitch cycles", 32'(bad), 32'd0);
        chk("quiet hover_valid", 32'(mcd_if.hover_valid), 32'd1);
        chk("quiet hover_col",   32'(mcd_if.hover_col),   32'd3);
        chk("quiet hover_row",   32'(mcd_if.hover_row),   32'd1);
        chk("quiet click_col",   32'(mcd_if.click_col),   32'd3);
        chk("quiet click_row",   32'(mcd_if.click_row),   32'd1);
        chk("quiet drag_active", 32'(mcd_if.drag_active), 32'd0);
        chk("quiet drag_col",    32'(mcd_if.drag_col),    32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mouse_click_decoder.md
MOUSE_CLICK_DECODER -- requirements
Module: mouse_click_decoder

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
  GRID_X0  0  grid left edge, px
  GRID_Y0  0  grid top edge, px
  CELL_SHIFT  5  log2 of square cell size, px
  GRID_COLS  20  cell columns, 1..32
  GRID_ROWS  15  cell rows, 1..32
  DBL_CYCLES  32400000  double-click window in clk cycles (300 ms at 108 MHz)
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
  clk  in  1  system/pixel clock, 108 MHz
  rst  in  1  reset, asynchronous, active-high
  mouse_x  in  10  cursor x, px
  mouse_y  in  10  cursor y, px
  mouse_left  in  1  left button level
  mouse_right  in  1  right button level
  mouse_new_event  in  1  one-cycle strobe; x/y/buttons valid this cycle
  hover_valid  out  1  cursor inside grid
  hover_col  out  5  cell column under cursor
  hover_row  out  5  cell row under cursor
  click_pulse  out  1  one-cycle click strobe
  click_button  out  1  0 = left, 1 = right; valid with click_pulse
  click_dbl  out  1  double-click qualifier; valid with click_pulse
  click_col  out  5  clicked cell column
  click_row  out  5  clicked cell row
  drag_active  out  1  left-button drag in progress
  drag_col  out  5  drag anchor column
  drag_row  out  5  drag anchor row

Function
REQ-003 Inputs SHALL be sampled only on cycles with mouse_new_event=1; x/y/button changes without a strobe SHALL have no effect.
REQ-004 Pipeline: strobe cycle N -> sample registers at N+1 -> registered outputs at N+2; every output change caused by an event SHALL appear exactly 2 cycles after the strobe.
REQ-005 Inside test: GRID_X0 <= x < GRID_X0+(GRID_COLS<<CELL_SHIFT), same form for y; compare in 11-bit unsigned, no wrap.
REQ-006 Cell: col=(x-GRID_X0)>>CELL_SHIFT, row=(y-GRID_Y0)>>CELL_SHIFT; outside grid: hover_valid=0, hover_col/row hold last inside value.
REQ-007 Button edges SHALL be computed against the previously sampled button levels (reset value 0).
REQ-008 FSM states IDLE, L_PRESS, L_DRAG, R_PRESS; anchor cell captured on entering L_PRESS or R_PRESS.
REQ-009 IDLE: left rising edge and inside -> L_PRESS; else right rising edge, left=0, inside -> R_PRESS; press outside grid ignored, stay IDLE.
REQ-010 Left and right rising edges in the same event: left wins -> L_PRESS.
REQ-011 L_PRESS: left released, inside, cell==anchor -> left click, IDLE; released elsewhere -> IDLE, no click; held and (cell!=anchor or outside) -> L_DRAG; right-button activity ignored.
REQ-012 L_DRAG: drag_active=1, drag_col/row=anchor; left release -> IDLE, drag_active=0, no click_pulse.
REQ-013 R_PRESS: right released in anchor cell -> right click, IDLE; released elsewhere -> IDLE, no click; left rising edge -> abort to IDLE, no click.
REQ-014 click_pulse SHALL be high exactly one cycle per click, with click_col/row = release cell; those outputs hold until the next click.
REQ-015 Double-click counter: 25-bit, loaded with DBL_CYCLES on every left click, decrements each cycle, saturates at 0.
REQ-016 A left click with counter>0 and same cell as the previous left click SHALL set click_dbl=1 and clear the counter (triple click = dbl then single); a right click SHALL clear the counter.

Reset
REQ-017 rst=1 SHALL immediately (asynchronously) force state IDLE, all outputs 0, counter 0, sampled button levels 0, pipeline registers 0.
REQ-018 Reset mid-press or mid-drag SHALL emit no click on the later release; a button still held after reset SHALL be treated as a rising edge on the first following event.

Verification
REQ-019 Bench SHALL cover (defaults):
  - event (100,40,L=1), then (101,41,L=0) -> click_pulse 1 cycle, 2 cycles after 2nd strobe, button=0, col=3, row=1, dbl=0.
  - repeat same click 1000 cycles later -> click_dbl=1; a third click -> click_dbl=0; click after DBL_CYCLES+1 idle -> click_dbl=0.
  - press (100,40), event (200,40,L=1) -> drag_active=1, drag_col=3, drag_row=1; release -> drag_active=0, no click_pulse.
  - (700,40) -> hover_valid=0, press/release there -> no click; (639,479) -> hover_valid=1, col=19, row=14.
  - rst pulse while in L_DRAG -> drag_active=0 same cycle; subsequent release -> no click_pulse.
  - mouse_x/mouse_left toggled with mouse_new_event=0 for 100 cycles -> all outputs unchanged.
